// File: rtl/xadac_pkg.sv
// Shared types and defaults for the xadac execution-unit datapath.
package xadac_pkg;

    localparam int unsigned DefNumReq         = 2;
    localparam int unsigned DefIdWidth        = 3;
    localparam int unsigned DefAddrWidth      = 32;
    localparam int unsigned DefDataWidth      = 64;
    localparam int unsigned DefMaxOutstanding = 8;

    // Width of a requester-index prefix; at least one bit even for a single requester.
    function automatic int unsigned sel_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned DefSelWidth = sel_width(DefNumReq);

    typedef logic [DefIdWidth-1:0]   IdT;
    typedef logic [DefAddrWidth-1:0] AddrT;
    typedef logic [DefDataWidth-1:0] VecDataT;
    typedef logic [DefSelWidth-1:0]  ArbSelT;

    // Master-side read ID: requester index prefixed to the requester's own ID.
    typedef struct packed {
        ArbSelT sel;
        IdT     id;
    } MstIdT;

endpackage

// File: rtl/xadac_rr_arb.sv
// Round-robin arbiter: first active request at or after the pointer wins.
module xadac_rr_arb
    import xadac_pkg::*;
#(
    parameter int unsigned NumReq   = DefNumReq,
    parameter int unsigned SelWidth = sel_width(NumReq)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NumReq-1:0]   req_i,
    input  logic                en_i,
    output logic [NumReq-1:0]   gnt_o,
    output logic [SelWidth-1:0] idx_o
);

    logic [SelWidth-1:0] ptr_q;
    logic [SelWidth-1:0] ptr_d;
    logic                found;
    int unsigned         pos;

    // Scan ptr, ptr+1, ... modulo NumReq; pointer moves past the winner only on a grant.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        pos   = 0;
        ptr_d = ptr_q;
        for (int unsigned k = 0; k < NumReq; k++) begin
            pos = 32'(ptr_q) + k;
            if (pos >= NumReq) begin
                pos = pos - NumReq;
            end
            for (int unsigned r = 0; r < NumReq; r++) begin
                if (!found && (pos == r) && req_i[r]) begin
                    found    = 1'b1;
                    idx_o    = SelWidth'(r);
                    gnt_o[r] = en_i;
                end
            end
        end
        if (en_i && found) begin
            ptr_d = ((32'(idx_o) + 1) >= NumReq) ? '0 : SelWidth'(32'(idx_o) + 1);
        end
    end

    // Priority pointer register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/xadac_axi_rd_arb.sv
// Shares one single-beat AXI read port (AR/R) between several xadac load units,
// with round-robin AR arbitration, ID-prefix R routing and per-requester credits.
module xadac_axi_rd_arb
    import xadac_pkg::*;
#(
    parameter int unsigned NumReq         = DefNumReq,
    parameter int unsigned IdWidth        = DefIdWidth,
    parameter int unsigned AddrWidth      = DefAddrWidth,
    parameter int unsigned DataWidth      = DefDataWidth,
    parameter int unsigned MaxOutstanding = DefMaxOutstanding,
    parameter int unsigned SelWidth       = sel_width(NumReq)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NumReq*IdWidth-1:0]     req_ar_id_i,
    input  logic [NumReq*AddrWidth-1:0]   req_ar_addr_i,
    input  logic [NumReq-1:0]             req_ar_valid_i,
    output logic [NumReq-1:0]             req_ar_ready_o,
    output logic [IdWidth-1:0]            req_r_id_o,
    output logic [DataWidth-1:0]          req_r_data_o,
    output logic [NumReq-1:0]             req_r_valid_o,
    input  logic [NumReq-1:0]             req_r_ready_i,
    output logic [SelWidth+IdWidth-1:0]   mst_ar_id_o,
    output logic [AddrWidth-1:0]          mst_ar_addr_o,
    output logic                          mst_ar_valid_o,
    input  logic                          mst_ar_ready_i,
    input  logic [SelWidth+IdWidth-1:0]   mst_r_id_i,
    input  logic [DataWidth-1:0]          mst_r_data_i,
    input  logic                          mst_r_valid_i,
    output logic                          mst_r_ready_o,
    output logic                          err_unmapped_o
);

    localparam int unsigned MstIdWidth = SelWidth + IdWidth;
    localparam int unsigned CntWidth   = $clog2(MaxOutstanding + 1);

    logic                  slot_free;
    logic [NumReq-1:0]     elig;
    logic [NumReq-1:0]     gnt;
    logic [SelWidth-1:0]   win_idx;

    logic                  mst_ar_valid_q, mst_ar_valid_d;
    logic [MstIdWidth-1:0] mst_ar_id_q,    mst_ar_id_d;
    logic [AddrWidth-1:0]  mst_ar_addr_q,  mst_ar_addr_d;

    logic [CntWidth-1:0]   cnt_q [NumReq];
    logic [CntWidth-1:0]   cnt_d [NumReq];
    logic                  err_q, err_d;

    logic [SelWidth-1:0]   r_sel;
    logic                  r_mapped;
    logic [NumReq-1:0]     r_hs;

    // Slot is free when empty or draining this cycle; requesters at their credit limit sit out.
    always_comb begin
        slot_free = !mst_ar_valid_q || mst_ar_ready_i;
        elig      = '0;
        for (int unsigned r = 0; r < NumReq; r++) begin
            elig[r] = req_ar_valid_i[r] && (32'(cnt_q[r]) < MaxOutstanding);
        end
    end

    xadac_rr_arb #(
        .NumReq   (NumReq),
        .SelWidth (SelWidth)
    ) u_rr_arb (
        .clk   (clk),
        .rst   (rst),
        .req_i (elig),
        .en_i  (slot_free && !rst),
        .gnt_o (gnt),
        .idx_o (win_idx)
    );

    assign req_ar_ready_o = gnt;

    // Master AR stage: load the winner, hold while stalled, empty when drained with no grant.
    always_comb begin
        mst_ar_valid_d = mst_ar_valid_q;
        mst_ar_id_d    = mst_ar_id_q;
        mst_ar_addr_d  = mst_ar_addr_q;
        if (|gnt) begin
            mst_ar_valid_d = 1'b1;
            for (int unsigned r = 0; r < NumReq; r++) begin
                if (gnt[r]) begin
                    mst_ar_id_d   = {win_idx, req_ar_id_i[r*IdWidth +: IdWidth]};
                    mst_ar_addr_d = req_ar_addr_i[r*AddrWidth +: AddrWidth];
                end
            end
        end else if (slot_free) begin
            mst_ar_valid_d = 1'b0;
        end
    end

    // R routing by ID prefix; beats with an out-of-range prefix are accepted and dropped.
    always_comb begin
        r_sel         = mst_r_id_i[MstIdWidth-1 -: SelWidth];
        r_mapped      = 32'(r_sel) < NumReq;
        req_r_valid_o = '0;
        mst_r_ready_o = !r_mapped;
        for (int unsigned r = 0; r < NumReq; r++) begin
            if (r_sel == SelWidth'(r)) begin
                req_r_valid_o[r] = mst_r_valid_i;
                mst_r_ready_o    = req_r_ready_i[r];
            end
        end
        r_hs = req_r_valid_o & req_r_ready_i;
    end

    assign req_r_id_o   = mst_r_id_i[IdWidth-1:0];
    assign req_r_data_o = mst_r_data_i;

    // Credit counters (grant +1, R handshake -1, floor at zero) and sticky unmapped flag.
    always_comb begin
        for (int unsigned r = 0; r < NumReq; r++) begin
            cnt_d[r] = cnt_q[r];
            if (gnt[r] && !r_hs[r]) begin
                cnt_d[r] = cnt_q[r] + CntWidth'(1);
            end else if (!gnt[r] && r_hs[r] && (cnt_q[r] != '0)) begin
                cnt_d[r] = cnt_q[r] - CntWidth'(1);
            end
        end
        err_d = err_q || (mst_r_valid_i && !r_mapped);
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mst_ar_valid_q <= 1'b0;
            mst_ar_id_q    <= '0;
            mst_ar_addr_q  <= '0;
            err_q          <= 1'b0;
            for (int unsigned r = 0; r < NumReq; r++) begin
                cnt_q[r] <= '0;
            end
        end else begin
            mst_ar_valid_q <= mst_ar_valid_d;
            mst_ar_id_q    <= mst_ar_id_d;
            mst_ar_addr_q  <= mst_ar_addr_d;
            err_q          <= err_d;
            for (int unsigned r = 0; r < NumReq; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
        end
    end

    assign mst_ar_valid_o = mst_ar_valid_q;
    assign mst_ar_id_o    = mst_ar_id_q;
    assign mst_ar_addr_o  = mst_ar_addr_q;
    assign err_unmapped_o = err_q;

endmodule

// File: tb/tb_xadac_axi_rd_arb.sv
// Scoreboard bench for xadac_axi_rd_arb with three requesters and a credit limit of two.
module tb_xadac_axi_rd_arb;

    localparam int unsigned NR = 3;
    localparam int unsigned IW = 3;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 64;
    localparam int unsigned MO = 2;

    typedef struct packed { logic [4:0] id; logic [31:0] addr; } exp_ar_t;
    typedef struct packed { logic [2:0] id; logic [31:0] addr; } req_ar_t;
    typedef struct packed { logic [1:0] dst; logic [2:0] id; logic [63:0] data; } exp_r_t;
    typedef struct packed { logic [4:0] id; logic [63:0] data; } beat_t;

    logic           clk = 1'b0;
    logic           rst;
    logic [8:0]     req_ar_id;
    logic [95:0]    req_ar_addr;
    logic [2:0]     req_ar_valid;
    logic [2:0]     req_ar_ready;
    logic [2:0]     req_r_id;
    logic [63:0]    req_r_data;
    logic [2:0]     req_r_valid;
    logic [2:0]     req_r_ready;
    logic [4:0]     mst_ar_id;
    logic [31:0]    mst_ar_addr;
    logic           mst_ar_valid;
    logic           mst_ar_ready;
    logic [4:0]     mst_r_id;
    logic [63:0]    mst_r_data;
    logic           mst_r_valid;
    logic           mst_r_ready;
    logic           err_unmapped;

    int n_tests = 0;
    int n_fail  = 0;

    exp_ar_t exp_ar [$];
    exp_r_t  exp_r  [$];
    req_ar_t pend0  [$];
    req_ar_t pend1  [$];
    req_ar_t pend2  [$];
    beat_t   rq     [$];

    logic [2:0] ar_hs;
    logic       r_hs_tb;

    xadac_axi_rd_arb #(
        .NumReq         (NR),
        .IdWidth        (IW),
        .AddrWidth      (AW),
        .DataWidth      (DW),
        .MaxOutstanding (MO)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req_ar_id_i    (req_ar_id),
        .req_ar_addr_i  (req_ar_addr),
        .req_ar_valid_i (req_ar_valid),
        .req_ar_ready_o (req_ar_ready),
        .req_r_id_o     (req_r_id),
        .req_r_data_o   (req_r_data),
        .req_r_valid_o  (req_r_valid),
        .req_r_ready_i  (req_r_ready),
        .mst_ar_id_o    (mst_ar_id),
        .mst_ar_addr_o  (mst_ar_addr),
        .mst_ar_valid_o (mst_ar_valid),
        .mst_ar_ready_i (mst_ar_ready),
        .mst_r_id_i     (mst_r_id),
        .mst_r_data_i   (mst_r_data),
        .mst_r_valid_i  (mst_r_valid),
        .mst_r_ready_o  (mst_r_ready),
        .err_unmapped_o (err_unmapped)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic q_ar(input int r, input logic [2:0] id, input logic [31:0] addr);
        req_ar_t t;
        t.id   = id;
        t.addr = addr;
        case (r)
            0:       pend0.push_back(t);
            1:       pend1.push_back(t);
            default: pend2.push_back(t);
        endcase
    endtask

    task automatic e_ar(input logic [4:0] id, input logic [31:0] addr);
        exp_ar_t t;
        t.id   = id;
        t.addr = addr;
        exp_ar.push_back(t);
    endtask

    task automatic q_r(input logic [4:0] id, input logic [63:0] data);
        beat_t t;
        t.id   = id;
        t.data = data;
        rq.push_back(t);
    endtask

    task automatic e_r(input logic [1:0] dst, input logic [2:0] id, input logic [63:0] data);
        exp_r_t t;
        t.dst  = dst;
        t.id   = id;
        t.data = data;
        exp_r.push_back(t);
    endtask

    // Drive the head of every requester queue and of the master R queue.
    task automatic present();
        req_ar_valid[0] = (pend0.size() != 0);
        req_ar_valid[1] = (pend1.size() != 0);
        req_ar_valid[2] = (pend2.size() != 0);
        if (pend0.size() != 0) begin req_ar_id[2:0] = pend0[0].id; req_ar_addr[31:0]  = pend0[0].addr; end
        if (pend1.size() != 0) begin req_ar_id[5:3] = pend1[0].id; req_ar_addr[63:32] = pend1[0].addr; end
        if (pend2.size() != 0) begin req_ar_id[8:6] = pend2[0].id; req_ar_addr[95:64] = pend2[0].addr; end
        mst_r_valid = (rq.size() != 0);
        if (rq.size() != 0) begin
            mst_r_id   = rq[0].id;
            mst_r_data = rq[0].data;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (ar_hs[0] && pend0.size() != 0) pend0.delete(0);
        if (ar_hs[1] && pend1.size() != 0) pend1.delete(0);
        if (ar_hs[2] && pend2.size() != 0) pend2.delete(0);
        if (r_hs_tb && rq.size() != 0) rq.delete(0);
        present();
    endtask

    task automatic wait_idle(input string name);
        int cyc;
        cyc = 0;
        while (((pend0.size() != 0) || (pend1.size() != 0) || (pend2.size() != 0) ||
                (rq.size() != 0) || (exp_ar.size() != 0) || (exp_r.size() != 0)) && cyc < 200) begin
            tick();
            cyc++;
        end
        if (cyc >= 200) begin
            n_tests++;
            n_fail++;
            $display("FAIL timeout %s: got %0d pending AR expectations, expected 0", name, exp_ar.size());
        end
    endtask

    task automatic wait_exp(input string name);
        int cyc;
        cyc = 0;
        while (((exp_ar.size() != 0) || (exp_r.size() != 0)) && cyc < 200) begin
            tick();
            cyc++;
        end
        if (cyc >= 200) begin
            n_tests++;
            n_fail++;
            $display("FAIL timeout %s: got %0d pending AR expectations, expected 0", name, exp_ar.size());
        end
    endtask

    // Handshake capture for the stimulus drivers.
    always @(negedge clk) begin
        ar_hs   <= rst ? 3'b000 : (req_ar_valid & req_ar_ready);
        r_hs_tb <= !rst && mst_r_valid && mst_r_ready;
    end

    // Monitor: every master AR handshake and requester R handshake pops one expectation.
    always @(negedge clk) begin
        if (!rst) begin
            if (mst_ar_valid && mst_ar_ready) begin
                if (exp_ar.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL ar_unexpected: got id 0x%0h addr 0x%0h, expected no AR", mst_ar_id, mst_ar_addr);
                end else begin
                    exp_ar_t e;
                    e = exp_ar.pop_front();
                    check("ar_id", 64'(mst_ar_id), 64'(e.id));
                    check("ar_addr", 64'(mst_ar_addr), 64'(e.addr));
                end
            end
            for (int r = 0; r < 3; r++) begin
                if (req_r_valid[r] && req_r_ready[r]) begin
                    if (exp_r.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL r_unexpected: got beat to requester %0d id 0x%0h, expected none", r, req_r_id);
                    end else begin
                        exp_r_t e;
                        e = exp_r.pop_front();
                        check("r_dst", 64'(r), 64'(e.dst));
                        check("r_id", 64'(req_r_id), 64'(e.id));
                        check("r_data", req_r_data, e.data);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst          = 1'b1;
        req_ar_id    = '0;
        req_ar_addr  = '0;
        req_ar_valid = '0;
        req_r_ready  = 3'b111;
        mst_ar_ready = 1'b1;
        mst_r_id     = '0;
        mst_r_data   = '0;
        mst_r_valid  = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ar_valid", 64'(mst_ar_valid), 64'd0);
        check("rst_ar_id", 64'(mst_ar_id), 64'd0);
        check("rst_ar_addr", 64'(mst_ar_addr), 64'd0);
        check("rst_err", 64'(err_unmapped), 64'd0);
        check("rst_ar_ready", 64'(req_ar_ready), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Single requester 0, then its R beat.
        q_ar(0, 3'd5, 32'h1000);
        e_ar(5'h05, 32'h1000);
        present();
        wait_idle("t1_ar");
        q_r(5'h05, 64'hDEAD);
        e_r(2'd0, 3'd5, 64'hDEAD);
        present();
        wait_idle("t1_r");

        // Both requesters continuously valid: pointer is 1, so grants go 1,0,1,0.
        q_ar(0, 3'd1, 32'h2000);
        q_ar(0, 3'd2, 32'h2004);
        q_ar(1, 3'd3, 32'h3000);
        q_ar(1, 3'd4, 32'h3004);
        e_ar(5'h0B, 32'h3000);
        e_ar(5'h01, 32'h2000);
        e_ar(5'h0C, 32'h3004);
        e_ar(5'h02, 32'h2004);
        present();
        wait_idle("t2_ar");
        q_r(5'h01, 64'hA);
        q_r(5'h02, 64'hB);
        q_r(5'h0B, 64'hC);
        q_r(5'h0C, 64'hD);
        e_r(2'd0, 3'd1, 64'hA);
        e_r(2'd0, 3'd2, 64'hB);
        e_r(2'd1, 3'd3, 64'hC);
        e_r(2'd1, 3'd4, 64'hD);
        present();
        wait_idle("t2_r");

        // Master stall for 4 cycles: held AR, no grants, then the other requester wins.
        mst_ar_ready = 1'b0;
        q_ar(0, 3'd5, 32'h4000);
        q_ar(0, 3'd6, 32'h4004);
        q_ar(1, 3'd7, 32'h5000);
        q_ar(1, 3'd0, 32'h5004);
        e_ar(5'h0F, 32'h5000);
        e_ar(5'h05, 32'h4000);
        e_ar(5'h08, 32'h5004);
        e_ar(5'h06, 32'h4004);
        present();
        tick();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("stall_ar_ready", 64'(req_ar_ready), 64'd0);
            check("stall_ar_valid", 64'(mst_ar_valid), 64'd1);
            check("stall_ar_id", 64'(mst_ar_id), 64'h0F);
            check("stall_ar_addr", 64'(mst_ar_addr), 64'h5000);
            tick();
        end
        mst_ar_ready = 1'b1;
        wait_idle("t3_ar");
        q_r(5'h0F, 64'h11);
        q_r(5'h05, 64'h22);
        q_r(5'h08, 64'h33);
        q_r(5'h06, 64'h44);
        e_r(2'd1, 3'd7, 64'h11);
        e_r(2'd0, 3'd5, 64'h22);
        e_r(2'd1, 3'd0, 64'h33);
        e_r(2'd0, 3'd6, 64'h44);
        present();
        wait_idle("t3_r");

        // Credit limit: requester 1 stalls after two ARs, requester 0 still wins.
        q_ar(1, 3'd1, 32'h6000);
        q_ar(1, 3'd2, 32'h6004);
        q_ar(1, 3'd3, 32'h6008);
        e_ar(5'h09, 32'h6000);
        e_ar(5'h0A, 32'h6004);
        present();
        tick();
        tick();
        q_ar(0, 3'd4, 32'h7000);
        e_ar(5'h04, 32'h7000);
        present();
        @(negedge clk);
        check("credit_r0_wins", 64'(req_ar_ready), 64'b001);
        tick();
        q_r(5'h09, 64'h1111);
        e_r(2'd1, 3'd1, 64'h1111);
        e_ar(5'h0B, 32'h6008);
        present();
        @(negedge clk);
        check("credit_r1_blocked", 64'(req_ar_ready), 64'b000);
        tick();
        wait_idle("t4");

        // R backpressure on requester 0 holds the beat.
        req_r_ready = 3'b110;
        q_r(5'h04, 64'hBEEF);
        e_r(2'd0, 3'd4, 64'hBEEF);
        present();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("bp_r_valid", 64'(req_r_valid), 64'b001);
            check("bp_mst_r_ready", 64'(mst_r_ready), 64'd0);
            check("bp_r_id", 64'(req_r_id), 64'd4);
            check("bp_r_data", req_r_data, 64'hBEEF);
            tick();
        end
        req_r_ready = 3'b111;
        wait_idle("t5_bp");

        // Requester 1 back to one credit, then grant and R handshake in the same cycle.
        q_r(5'h0A, 64'h2222);
        e_r(2'd1, 3'd2, 64'h2222);
        present();
        wait_idle("t5_r");
        q_ar(1, 3'd6, 32'h6010);
        e_ar(5'h0E, 32'h6010);
        q_r(5'h0B, 64'h3333);
        e_r(2'd1, 3'd3, 64'h3333);
        present();
        wait_idle("t5_sim");
        q_ar(1, 3'd7, 32'h6014);
        q_ar(1, 3'd0, 32'h6018);
        e_ar(5'h0F, 32'h6014);
        present();
        wait_exp("t5_limit");
        @(negedge clk);
        check("sim_cnt_limit_ready", 64'(req_ar_ready), 64'd0);
        tick();
        @(negedge clk);
        check("sim_cnt_limit_ready2", 64'(req_ar_ready), 64'd0);
        check("sim_cnt_limit_valid", 64'(mst_ar_valid), 64'd0);
        tick();

        // Unmapped prefix 3: dropped, sticky error one cycle later.
        q_r(5'h1A, 64'h5555);
        present();
        @(negedge clk);
        check("unmap_mst_r_ready", 64'(mst_r_ready), 64'd1);
        check("unmap_r_valid", 64'(req_r_valid), 64'd0);
        check("unmap_err_early", 64'(err_unmapped), 64'd0);
        tick();
        @(negedge clk);
        check("unmap_err_set", 64'(err_unmapped), 64'd1);
        tick();
        @(negedge clk);
        check("unmap_err_hold", 64'(err_unmapped), 64'd1);
        tick();

        // Reset in the middle of a stalled AR.
        mst_ar_ready = 1'b0;
        q_ar(0, 3'd1, 32'h8000);
        present();
        tick();
        tick();
        @(negedge clk);
        check("pre_rst_ar_valid", 64'(mst_ar_valid), 64'd1);
        check("pre_rst_ar_id", 64'(mst_ar_id), 64'h01);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_ar_valid", 64'(mst_ar_valid), 64'd0);
        check("mid_rst_ar_id", 64'(mst_ar_id), 64'd0);
        check("mid_rst_ar_addr", 64'(mst_ar_addr), 64'd0);
        check("mid_rst_err", 64'(err_unmapped), 64'd0);
        check("mid_rst_ar_ready", 64'(req_ar_ready), 64'd0);
        pend0.delete();
        pend1.delete();
        pend2.delete();
        rq.delete();
        exp_ar.delete();
        exp_r.delete();
        present();
        mst_ar_ready = 1'b1;
        tick();
        rst = 1'b0;

        // After reset: pointer at 0 and requester 1 has its full credit again.
        q_ar(0, 3'd4, 32'hB000);
        q_ar(1, 3'd1, 32'h9000);
        q_ar(1, 3'd2, 32'h9004);
        q_ar(2, 3'd3, 32'hA000);
        e_ar(5'h04, 32'hB000);
        e_ar(5'h09, 32'h9000);
        e_ar(5'h13, 32'hA000);
        e_ar(5'h0A, 32'h9004);
        present();
        wait_idle("t6_post_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
